// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and FSM state type for the mux scan controller.
// Exports N_CH (channel count), SEL_W (select width), CNT_W (settle counter
// width) and the scan FSM state enum.
package mux_pkg;
    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
endpackage

// File: rtl/mux_scan_ctrl_ch_next_find.sv
// ch_next_find: finds the lowest enabled channel strictly above a given index.
// Ports:
//   mask_i  - channel enable mask
//   idx_i   - current channel index
//   nxt_o   - lowest enabled channel with index > idx_i (0 when none)
//   found_o - high when such a channel exists
module ch_next_find import mux_pkg::*; (
    input  logic [N_CH-1:0]  mask_i,
    input  logic [SEL_W-1:0] idx_i,
    output logic [SEL_W-1:0] nxt_o,
    output logic             found_o
);
    // Scan downwards so the last hit, i.e. the lowest qualifying channel, wins.
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask_i[k] && k > int'(idx_i)) begin
                nxt_o   = SEL_W'(k);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps an external 8:1 mux over the enabled channels, samples
// its output after a settle delay and hands the assembled word to a consumer.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - scan request, honoured in IDLE only
//   ch_mask             - channel enables, latched when a scan is accepted
//   sel                 - select to the downstream mux
//   y_in                - mux output fed back for sampling
//   data, data_valid    - assembled word and its valid flag
//   data_ready          - consumer accept
//   busy                - high whenever the FSM is not in IDLE
module mux_scan_ctrl import mux_pkg::*; #(
    parameter int SETTLE_CYC = 1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_CH-1:0]  ch_mask,
    output logic [SEL_W-1:0] sel,
    input  logic             y_in,
    output logic [N_CH-1:0]  data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy
);
    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_CH-1:0]   data_q, data_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   first_mask;
    logic [SEL_W-1:0]  first_nx, first_sel, nxt_sel;
    logic              first_found, nxt_found, settle_done, accept, handshake, restart;
    // A fresh scan uses the live mask from IDLE, a continuous restart the latched one.
    assign first_mask  = (state_q == IDLE) ? ch_mask : mask_q;
    assign first_sel   = first_mask[0] ? '0 : first_nx;
    assign settle_done = cnt_q == CNT_W'(SETTLE_CYC - 1);
    assign accept      = (state_q == IDLE) && start;
    assign handshake   = (state_q == DONE) && data_ready;
    assign restart     = accept || (handshake && CONTINUOUS);
    ch_next_find u_first (
        .mask_i (first_mask),
        .idx_i  ('0),
        .nxt_o  (first_nx),
        .found_o(first_found)
    );
    ch_next_find u_next (
        .mask_i (mask_q),
        .idx_i  (sel_q),
        .nxt_o  (nxt_sel),
        .found_o(nxt_found)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = |ch_mask ? SETTLE : DONE;
            SETTLE:  if (settle_done) state_d = SAMPLE;
            SAMPLE:  state_d = nxt_found ? SETTLE : DONE;
            DONE:    if (data_ready) state_d = !CONTINUOUS ? IDLE : (first_found || first_mask[0]) ? SETTLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // Datapath next-state; sel and data only move on a (re)start or a sample,
    // so they hold steady through SETTLE and DONE.
    always_comb begin
        mask_d = accept ? ch_mask : mask_q;
        cnt_d  = (state_q == SETTLE && !settle_done) ? cnt_q + 1'b1 : '0;
        data_d = restart ? '0 : data_q;
        if (!restart && state_q == SAMPLE) data_d[sel_q] = y_in;
        sel_d  = restart ? first_sel :
                 (state_q == SAMPLE && nxt_found) ? nxt_sel :
                 handshake ? '0 : sel_q;
    end
    assign sel        = sel_q;
    assign data       = data_q;
    assign data_valid = state_q == DONE;
    assign busy       = state_q != IDLE;
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1: cycles sel is held before y_in is sampled; legal range 1..15.
REQ-002 SHALL have parameter CONTINUOUS, default 0: 1 = restart the scan automatically after each handshake.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle scan request, sampled in IDLE only.
REQ-006 SHALL have port ch_mask  input  8  channel enables; bit k enables channel k; latched on accepted start.
REQ-007 SHALL have port sel  output  3  select driven to the downstream 8:1 mux; value k selects mux input i(k+1).
REQ-008 SHALL have port y_in  input  1  mux output y, fed back for sampling.
REQ-009 SHALL have port data  output  8  assembled scan word; bit k is the sampled value of channel k.
REQ-010 SHALL have port data_valid  output  1  data is complete and stable.
REQ-011 SHALL have port data_ready  input  1  consumer accepts data when data_valid && data_ready.
REQ-012 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE: start=1 SHALL latch ch_mask, clear data to 0, and set sel to the lowest enabled channel; next state SETTLE (or DONE if mask==0).
REQ-015 SETTLE: sel SHALL be held constant for exactly SETTLE_CYC cycles (4-bit counter), then SAMPLE.
REQ-016 SAMPLE (1 cycle): data[sel] SHALL be loaded with y_in; sel SHALL advance to the next higher enabled channel and the FSM SHALL go to SETTLE, or to DONE if no enabled channel remains.
REQ-017 Disabled channels SHALL never be driven on sel during a scan, and their data bits SHALL read 0.
REQ-018 Latency: with start accepted at edge 0 and N enabled channels, data_valid SHALL rise after edge 1+N*(SETTLE_CYC+1); for N=8 and SETTLE_CYC=1 this is edge 17.
REQ-019 Empty mask: data_valid SHALL rise after edge 1 with data=8'h00; sel SHALL stay 0.
REQ-020 DONE: data_valid=1; data and sel SHALL hold stable until the handshake, with no timeout.
REQ-021 The handshake cycle SHALL drop data_valid on the next edge; the FSM SHALL go to IDLE if CONTINUOUS=0, else re-enter the scan with the latched mask (data cleared, sel = lowest enabled channel).
REQ-022 start SHALL be ignored while busy=1, including in DONE.
REQ-023 data_ready SHALL be ignored while data_valid=0.
REQ-024 In CONTINUOUS mode, a changed ch_mask SHALL take effect only after returning through reset; the latched mask is reused.
REQ-025 sel SHALL be 0 in IDLE.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, sel=0, data=0, data_valid=0, busy=0, settle counter=0, latched mask=0.
REQ-027 Reset asserted mid-scan or in DONE SHALL discard the partial or pending word; no handshake SHALL complete afterwards.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-029 Shared package mux_pkg SHALL hold N_CH=8, SEL_W=3, and the FSM state enum.
REQ-030 Next-channel search SHALL be a combinational sub-module ch_next_find (inputs: mask, current index; outputs: next index, found flag); everything else SHALL stay in mux_scan_ctrl.

Verification
REQ-031 Full scan: mask=8'hFF, mux inputs i1..i8 = 1,0,1,1,0,0,1,0, SETTLE_CYC=1 -> sel steps 0..7, data=8'h4D valid after edge 17.
REQ-032 Sparse mask: mask=8'h81, all inputs=1 -> sel visits only 0 and 7, data=8'h81, valid after edge 5.
REQ-033 Back-pressure: hold data_ready=0 for 10 cycles in DONE -> data and sel stable, data_valid high; ready=1 -> valid low next edge, FSM in IDLE.
REQ-034 Empty mask with start, then extra start pulses while busy -> data=8'h00 valid after edge 1; the extra starts have no effect.
REQ-035 Reset mid-scan: rst_n low at edge 6 -> all outputs 0 immediately; a new start produces a clean, full-latency scan.
REQ-036 CONTINUOUS=1, mask=8'h0F, ready tied high -> back-to-back scans, each valid pulse one cycle wide, 9 cycles apart.
